alu_muldiv_seq: RTL and testbench

- Iterative 64-bit unsigned multiply/divide sequencer that reuses the shared 64-bit ALU instead of adding a dedicated multiplier or divider.
- Requests the ALU from the EX-stage arbiter and drives the ALU's A, B and control inputs. It advances only in cycles where the ALU is granted.
- Multiply uses shift-add with the ALU add op (010). Divide uses restoring division with the ALU subtract op (011) and its CarryOut.

---
 rtl/alu_muldiv_seq_pkg.sv | 22 ++
 rtl/alu_muldiv_seq_if.sv | 25 ++
 rtl/alu_muldiv_seq.sv | 162 ++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_muldiv_seq_pkg.sv
// Shared ALU op codes and the mul/div sequencer's op and state encodings.
package alu_pkg;

   localparam logic [2:0] ALU_PASS_B = 3'b000;
   localparam logic [2:0] ALU_ADD    = 3'b010;
   localparam logic [2:0] ALU_SUB    = 3'b011;
   localparam logic [2:0] ALU_AND    = 3'b100;
   localparam logic [2:0] ALU_OR     = 3'b101;
   localparam logic [2:0] ALU_XOR    = 3'b110;

   typedef enum logic {
      MD_MUL = 1'b0,
      MD_DIV = 1'b1
   } md_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } md_state_e;

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Request/operand/result bus between the mul/div sequencer (master) and the
// EX-stage arbiter plus shared ALU (slave).
interface alu_muldiv_seq_if #(
   parameter int WIDTH = 64
) ();

   logic             alu_req;
   logic             alu_gnt;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [2:0]       alu_ctrl;
   logic [WIDTH-1:0] alu_result;
   logic             alu_carry;

   modport master (
      output alu_req, alu_a, alu_b, alu_ctrl,
      input  alu_gnt, alu_result, alu_carry
   );

   modport slave (
      input  alu_req, alu_a, alu_b, alu_ctrl,
      output alu_gnt, alu_result, alu_carry
   );

endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative 64-bit unsigned multiply (shift-add) / divide (restoring) that
// borrows the shared ALU one granted cycle per iteration.
module alu_muldiv_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int ITER  = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   alu_muldiv_seq_if.master alu
);

   localparam int CNT_W = $clog2(ITER + 1);

   md_state_e        state_q, state_d;
   md_op_e           op_q, op_d;
   // acc holds P (MUL) or R (DIV); mc holds M (MUL, shifts) or D (DIV, fixed)
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mc_q, mc_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] res_lo_q, res_lo_d;
   logic [WIDTH-1:0] res_hi_q, res_hi_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [WIDTH-1:0] shl_s;
   logic             fire;
   logic             last;
   logic             sub_ok;
   logic             div_zero;

   assign shl_s    = {acc_q[WIDTH-2:0], q_q[WIDTH-1]};
   assign fire     = (state_q == RUN) && alu.alu_gnt;
   assign last     = fire && (cnt_q == CNT_W'(ITER - 1));
   // R[63] set means the shifted remainder exceeds any 64-bit divisor
   assign sub_ok   = alu.alu_carry | acc_q[WIDTH-1];
   assign div_zero = (md_op_e'(op) == MD_DIV) && (opb == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = div_zero ? DONE : RUN;
         RUN:     if (last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      op_d     = op_q;
      acc_d    = acc_q;
      mc_d     = mc_q;
      q_d      = q_q;
      cnt_d    = cnt_q;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d  = md_op_e'(op);
               cnt_d = '0;
               acc_d = '0;
               if (md_op_e'(op) == MD_MUL) begin
                  mc_d = opa;
                  q_d  = opb;
               end else begin
                  mc_d = opb;
                  q_d  = opa;
               end
               if (div_zero) begin
                  res_lo_d = '1;
                  res_hi_d = opa;
               end
            end
         end
         RUN: begin
            if (fire) begin
               cnt_d = cnt_q + 1'b1;
               if (op_q == MD_MUL) begin
                  if (q_q[0]) acc_d = alu.alu_result;
                  mc_d = mc_q << 1;
                  q_d  = q_q >> 1;
               end else if (sub_ok) begin
                  acc_d = alu.alu_result;
                  q_d   = {q_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_d = shl_s;
                  q_d   = {q_q[WIDTH-2:0], 1'b0};
               end
               // results capture the post-iteration values on the final edge
               if (last) begin
                  res_lo_d = (op_q == MD_MUL) ? acc_d : q_d;
                  res_hi_d = (op_q == MD_MUL) ? '0 : acc_d;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= MD_MUL;
         acc_q    <= '0;
         mc_q     <= '0;
         q_q      <= '0;
         cnt_q    <= '0;
         res_lo_q <= '0;
         res_hi_q <= '0;
      end else begin
         op_q     <= op_d;
         acc_q    <= acc_d;
         mc_q     <= mc_d;
         q_q      <= q_d;
         cnt_q    <= cnt_d;
         res_lo_q <= res_lo_d;
         res_hi_q <= res_hi_d;
      end
   end

   always_comb begin
      busy         = 1'b0;
      done         = 1'b0;
      alu.alu_req  = 1'b0;
      alu.alu_a    = '0;
      alu.alu_b    = '0;
      alu.alu_ctrl = ALU_PASS_B;
      case (state_q)
         RUN: begin
            busy        = 1'b1;
            alu.alu_req = 1'b1;
            alu.alu_b   = mc_q;
            if (op_q == MD_MUL) begin
               alu.alu_a    = acc_q;
               alu.alu_ctrl = ALU_ADD;
            end else begin
               alu.alu_a    = shl_s;
               alu.alu_ctrl = ALU_SUB;
            end
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   assign result_lo = res_lo_q;
   assign result_hi = res_hi_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a behavioural ALU and a scoreboard
// monitor that checks results whenever done is presented.
module tb_alu_muldiv_seq;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic [63:0] opa = '0;
   logic [63:0] opb = '0;
   logic        busy;
   logic        done;
   logic [63:0] result_lo;
   logic [63:0] result_hi;
   logic [64:0] alu_sum;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] lo;
      logic [63:0] hi;
      string       name;
   } exp_t;
   exp_t sb[$];

   alu_muldiv_seq_if #(.WIDTH(64)) alu_if ();

   alu_muldiv_seq #(.WIDTH(64), .ITER(64)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op        (op),
      .opa       (opa),
      .opb       (opb),
      .busy      (busy),
      .done      (done),
      .result_lo (result_lo),
      .result_hi (result_hi),
      .alu       (alu_if)
   );

   always #5 clk = ~clk;

   // shared ALU: SUB carry is "no borrow", i.e. a >= b
   always_comb begin
      alu_sum = '0;
      case (alu_if.alu_ctrl)
         ALU_ADD: alu_sum = {1'b0, alu_if.alu_a} + {1'b0, alu_if.alu_b};
         ALU_SUB: alu_sum = {1'b0, alu_if.alu_a} + {1'b0, ~alu_if.alu_b} + 65'd1;
         ALU_AND: alu_sum = {1'b0, alu_if.alu_a & alu_if.alu_b};
         ALU_OR:  alu_sum = {1'b0, alu_if.alu_a | alu_if.alu_b};
         ALU_XOR: alu_sum = {1'b0, alu_if.alu_a ^ alu_if.alu_b};
         default: alu_sum = {1'b0, alu_if.alu_b};
      endcase
   end
   assign alu_if.alu_result = alu_sum[63:0];
   assign alu_if.alu_carry  = alu_sum[64];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_zero(input string p);
      chk({p, "_busy"}, 64'(busy), 64'd0);
      chk({p, "_done"}, 64'(done), 64'd0);
      chk({p, "_req"}, 64'(alu_if.alu_req), 64'd0);
      chk({p, "_alu_a"}, alu_if.alu_a, 64'd0);
      chk({p, "_alu_b"}, alu_if.alu_b, 64'd0);
      chk({p, "_ctrl"}, 64'(alu_if.alu_ctrl), 64'd0);
      chk({p, "_res_lo"}, result_lo, 64'd0);
      chk({p, "_res_hi"}, result_hi, 64'd0);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending operation");
         end else begin
            e = sb.pop_front();
            chk({e.name, "_lo"}, result_lo, e.lo);
            chk({e.name, "_hi"}, result_hi, e.hi);
         end
      end
   end

   // gmode 0: grant always high; gmode 1: grant low on odd RUN cycles, high on even.
   // jab_at > 0 pulses start (with junk operands) in that RUN cycle.
   task automatic run_op(input string name, input logic o, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] elo, input logic [63:0] ehi,
                         input int gmode, input int elat, input int ebusy, input int jab_at);
      int n, nbusy, nreq;
      bit seen;
      logic [63:0] pb;
      @(negedge clk);
      start = 1'b1;
      op = o;
      opa = a;
      opb = b;
      alu_if.alu_gnt = (gmode == 0);
      sb.push_back('{lo: elo, hi: ehi, name: name});
      n = 0; nbusy = 0; nreq = 0; seen = 0;
      pb = alu_if.alu_b;
      while (n < 400 && !seen) begin
         @(negedge clk);
         n++;
         start = (n == jab_at);
         if (n == jab_at) begin
            opa = 64'hDEAD;
            opb = 64'h3;
         end
         if (done) seen = 1;
         else begin
            if (busy) nbusy++;
            if (alu_if.alu_req) nreq++;
            if (gmode == 1 && n > 1 && !alu_if.alu_gnt)
               chk({name, "_hold"}, alu_if.alu_b, pb);
            pb = alu_if.alu_b;
            alu_if.alu_gnt = (gmode == 0) ? 1'b1 : (n % 2 == 0);
         end
      end
      start = 1'b0;
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no done in 400 cycles expected done", name);
         sb.delete();
      end
      chk({name, "_latency"}, 64'(n), 64'(elat));
      chk({name, "_busy_cycles"}, 64'(nbusy), 64'(ebusy));
      chk({name, "_req_cycles"}, 64'(nreq), 64'(ebusy));
      @(negedge clk);
      chk({name, "_done_pulse"}, 64'(done), 64'd0);
      chk({name, "_idle_after"}, 64'(busy), 64'd0);
      chk({name, "_held_lo"}, result_lo, elo);
      chk({name, "_held_hi"}, result_hi, ehi);
   endtask

   initial begin
      int n, ndone;
      alu_if.alu_gnt = 1'b0;
      #1;
      chk_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_op("mul_7x6", 1'b0, 64'd7, 64'd6, 64'd42, 64'd0, 0, 65, 64, 0);
      run_op("mul_max_x2", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
             64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1, 129, 128, 0);
      run_op("div_100_7", 1'b1, 64'd100, 64'd7, 64'd14, 64'd2, 0, 65, 64, 10);
      run_op("div_max_1", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
             64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 65, 64, 0);
      run_op("div_r63", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
             64'd1, 64'h7FFF_FFFF_FFFF_FFFE, 0, 65, 64, 0);
      run_op("div_zero", 1'b1, 64'h1234, 64'd0,
             64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 0, 1, 0, 0);

      // reset at iteration 30 of a MUL after a stray start during RUN
      @(negedge clk);
      start = 1'b1; op = 1'b0; opa = 64'd9; opb = 64'd11;
      alu_if.alu_gnt = 1'b1;
      for (n = 1; n <= 30; n++) begin
         @(negedge clk);
         start = (n == 5);
      end
      start = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_zero("midrst");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      repeat (70) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("midrst_no_done", 64'(ndone), 64'd0);
      chk("midrst_idle", 64'(busy), 64'd0);

      run_op("mul_3x5", 1'b0, 64'd3, 64'd5, 64'd15, 64'd0, 0, 65, 64, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion by 500000 expected finish");
      $fatal(1, "watchdog");
   end

endmodule
